// File: rtl/otter_cu_pkg.sv
// ---------------------------------------------------------------------------
// otter_cu_pkg
// Shared constants for the OTTER multicycle control unit:
//   - RV32I major opcodes decoded by the control FSM
//   - FSM state codes (also visible on the STATE debug port)
//   - FUNC3 codes that split the SYSTEM opcode
//   - strobe bundle type and an opcode-class helper
// ---------------------------------------------------------------------------
package otter_cu_pkg;

    // RV32I major opcodes, ir[6:0]
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // FSM state codes; 5..7 are illegal
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_INTR  = 3'd4;

    // FUNC3 codes under SYSTEM
    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    // All control strobes driven by the FSM, grouped so one default clears them
    typedef struct packed {
        logic pc_we;
        logic rf_we;
        logic mem_rden1;
        logic mem_rden2;
        logic mem_we2;
        logic csr_we;
        logic int_taken;
        logic mret_exec;
        logic rst_out;
    } cu_strobes_t;

    // Opcodes that write rd in EXEC and then advance the PC
    function automatic logic is_rf_op(input logic [6:0] opcode);
        logic hit;
        case (opcode)
            OP, OP_IMM, LUI, AUIPC, JAL, JALR: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/otter_intr_latch.sv
// ---------------------------------------------------------------------------
// otter_intr_latch
// Captures a rising edge on the (already synchronous) interrupt request and
// holds it as PENDING until the FSM acknowledges by entering its interrupt
// state. A new edge arriving in the acknowledge cycle wins over the clear, so
// no request is lost. A level held high only counts once.
// Ports:
//   CLK     in   system clock
//   RST_N   in   asynchronous active-low reset
//   INTR    in   interrupt request level
//   CLR     in   acknowledge (FSM is in its interrupt state)
//   PENDING out  latched interrupt request
// ---------------------------------------------------------------------------
module otter_intr_latch (
    input  logic CLK,
    input  logic RST_N,
    input  logic INTR,
    input  logic CLR,
    output logic PENDING
);

    logic intr_d_q;
    logic pending_q;
    logic pending_d;
    logic rise_s;

    assign rise_s  = INTR & ~intr_d_q;
    assign PENDING = pending_q;

    // Next pending value: set beats clear, otherwise hold
    always_comb begin
        pending_d = pending_q;
        if (rise_s) begin
            pending_d = 1'b1;
        end else if (CLR) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Edge-detect history and pending flop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_d_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            intr_d_q  <= INTR;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// otter_cu_fsm
// Multicycle control FSM for the OTTER RV32I core. Walks each instruction
// through FETCH / EXEC (/ WB for loads) and, when an interrupt is pending and
// enabled at an instruction boundary, through INTR. Strobes are decoded
// combinationally from the registered state plus OPCODE/FUNC3.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   OPCODE, FUNC3         fields of the current instruction
//   INTR, CSR_MIE         interrupt request level, global interrupt enable
//   PC_WE                 PC register load enable
//   RF_WE                 register file write enable
//   MEM_RDEN1, MEM_RDEN2  instruction / data memory read enables
//   MEM_WE2               data memory write enable
//   CSR_WE                CSR write enable
//   INT_TAKEN, MRET_EXEC  PC mux steering hints (mtvec / mepc)
//   RST_OUT               synchronous clear to the PC register
//   INSTRET               retired-instruction counter
//   STATE                 current state code
// ---------------------------------------------------------------------------
module otter_cu_fsm
    import otter_cu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNC3,
    input  logic             INTR,
    input  logic             CSR_MIE,
    output logic             PC_WE,
    output logic             RF_WE,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             CSR_WE,
    output logic             INT_TAKEN,
    output logic             MRET_EXEC,
    output logic             RST_OUT,
    output logic [CNT_W-1:0] INSTRET,
    output logic [2:0]       STATE
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             pending_s;
    logic             take_intr_s;
    logic             clr_s;
    logic             retire_s;
    cu_strobes_t      str_s;

    // Acknowledge the latched request for the whole INTR cycle
    assign clr_s = (state_q == ST_INTR);

    otter_intr_latch u_intr_latch (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .INTR    (INTR),
        .CLR     (clr_s),
        .PENDING (pending_s)
    );

    // Interrupt entry only at an instruction boundary (end of EXEC or WB)
    assign take_intr_s = pending_s & CSR_MIE;

    // Strobe decode from state and instruction fields
    always_comb begin
        str_s = '0;
        case (state_q)
            ST_INIT:  str_s.rst_out   = 1'b1;
            ST_FETCH: str_s.mem_rden1 = 1'b1;
            ST_EXEC: begin
                case (OPCODE)
                    // Load holds the PC until WB has written rd
                    LOAD: str_s.mem_rden2 = 1'b1;
                    STORE: begin
                        str_s.mem_we2 = 1'b1;
                        str_s.pc_we   = 1'b1;
                    end
                    SYSTEM: begin
                        str_s.pc_we = 1'b1;
                        if (FUNC3 == F3_MRET) begin
                            str_s.mret_exec = 1'b1;
                        end else if (FUNC3 == F3_CSRRW) begin
                            str_s.csr_we = 1'b1;
                            str_s.rf_we  = 1'b1;
                        end else begin
                            str_s.csr_we = 1'b0;
                        end
                    end
                    // Register-writing ops, branches and unknown opcodes (NOP)
                    default: begin
                        str_s.pc_we = 1'b1;
                        str_s.rf_we = is_rf_op(OPCODE);
                    end
                endcase
            end
            ST_WB: begin
                str_s.rf_we = 1'b1;
                str_s.pc_we = 1'b1;
            end
            ST_INTR: begin
                str_s.int_taken = 1'b1;
                str_s.pc_we     = 1'b1;
            end
            default: str_s = '0;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_d = ST_INIT;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (OPCODE == LOAD) begin
                    state_d = ST_WB;
                end else if (take_intr_s) begin
                    state_d = ST_INTR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB: begin
                if (take_intr_s) begin
                    state_d = ST_INTR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_INTR: state_d = ST_FETCH;
            default: state_d = ST_INIT;
        endcase
    end

    // An instruction retires when EXEC or WB loads the PC; INTR never counts
    assign retire_s = str_s.pc_we & ((state_q == ST_EXEC) | (state_q == ST_WB));

    // Next retired-instruction count, wrapping naturally
    always_comb begin
        instret_d = instret_q;
        if (retire_s) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // State and counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_INIT;
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign PC_WE     = str_s.pc_we;
    assign RF_WE     = str_s.rf_we;
    assign MEM_RDEN1 = str_s.mem_rden1;
    assign MEM_RDEN2 = str_s.mem_rden2;
    assign MEM_WE2   = str_s.mem_we2;
    assign CSR_WE    = str_s.csr_we;
    assign INT_TAKEN = str_s.int_taken;
    assign MRET_EXEC = str_s.mret_exec;
    assign RST_OUT   = str_s.rst_out;
    assign INSTRET   = instret_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// tb_otter_cu_fsm
// Self-checking bench for otter_cu_fsm. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, and a behavioural model of the
// instruction sequencing advances on every rising edge.
// ---------------------------------------------------------------------------
module tb_otter_cu_fsm;

    localparam logic [6:0] C_LOAD   = 7'b0000011;
    localparam logic [6:0] C_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP     = 7'b0110011;
    localparam logic [6:0] C_SYSTEM = 7'b1110011;

    logic        CLK;
    logic        RST_N;
    logic [6:0]  op_r;
    logic [2:0]  f3_r;
    logic        intr_r;
    logic        mie_r;
    logic        PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE;
    logic        INT_TAKEN, MRET_EXEC, RST_OUT;
    logic [31:0] INSTRET;
    logic [2:0]  STATE;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the sequencer: phase numbers as given for the STATE port
    logic [2:0]  m_state;
    logic        m_pending;
    logic        m_intr_prev;
    logic [31:0] m_instret;
    logic [8:0]  exp_str;

    logic [6:0] op_tbl [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                                7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                7'b1100111, 7'b1110011, 7'b1110011, 7'b1110011};

    otter_cu_fsm #(.CNT_W(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .OPCODE    (op_r),
        .FUNC3     (f3_r),
        .INTR      (intr_r),
        .CSR_MIE   (mie_r),
        .PC_WE     (PC_WE),
        .RF_WE     (RF_WE),
        .MEM_RDEN1 (MEM_RDEN1),
        .MEM_RDEN2 (MEM_RDEN2),
        .MEM_WE2   (MEM_WE2),
        .CSR_WE    (CSR_WE),
        .INT_TAKEN (INT_TAKEN),
        .MRET_EXEC (MRET_EXEC),
        .RST_OUT   (RST_OUT),
        .INSTRET   (INSTRET),
        .STATE     (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected strobes {pc_we,rf_we,rden1,rden2,we2,csr_we,int_taken,mret,rst_out}
    function automatic logic [8:0] ref_strobes(input logic [2:0] st, input logic [6:0] op,
                                               input logic [2:0] f3);
        case (st)
            3'd0: return 9'b000000001;
            3'd1: return 9'b001000000;
            3'd2: begin
                case (op)
                    7'b0000011: return 9'b000100000;
                    7'b0100011: return 9'b100010000;
                    7'b0110011, 7'b0010011, 7'b0110111,
                    7'b0010111, 7'b1101111, 7'b1100111: return 9'b110000000;
                    7'b1110011: begin
                        if (f3 == 3'b000) return 9'b100000010;
                        if (f3 == 3'b001) return 9'b110001000;
                        return 9'b100000000;
                    end
                    default: return 9'b100000000;
                endcase
            end
            3'd3: return 9'b110000000;
            3'd4: return 9'b100000100;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic logic [8:0] obs_str();
        return {PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC, RST_OUT};
    endfunction

    task automatic model_reset();
        m_state     = 3'd0;
        m_pending   = 1'b0;
        m_intr_prev = 1'b0;
        m_instret   = 32'd0;
    endtask

    // One rising edge of the model, using the inputs presented this cycle
    task automatic model_step();
        logic [8:0] s;
        logic       rise;
        logic       take;
        logic [2:0] nxt;
        s    = ref_strobes(m_state, op_r, f3_r);
        rise = intr_r && !m_intr_prev;
        take = m_pending && mie_r;
        if ((m_state == 3'd2 || m_state == 3'd3) && s[8]) m_instret = m_instret + 32'd1;
        case (m_state)
            3'd0: nxt = 3'd1;
            3'd1: nxt = 3'd2;
            3'd2: nxt = (op_r == C_LOAD) ? 3'd3 : (take ? 3'd4 : 3'd1);
            3'd3: nxt = take ? 3'd4 : 3'd1;
            3'd4: nxt = 3'd1;
            default: nxt = 3'd0;
        endcase
        if (rise) m_pending = 1'b1;
        else if (m_state == 3'd4) m_pending = 1'b0;
        m_intr_prev = intr_r;
        m_state     = nxt;
    endtask

    // Present inputs for the current cycle (called just after a falling edge)
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic intr,
                         input logic mie);
        op_r   = op;
        f3_r   = f3;
        intr_r = intr;
        mie_r  = mie;
        #1;
        exp_str = ref_strobes(m_state, op, f3);
    endtask

    // Advance to the next cycle
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N  = 1'b0;
        op_r   = 7'd0;
        f3_r   = 3'd0;
        intr_r = 1'b0;
        mie_r  = 1'b0;
        #2;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST_N  = 1'b0;
        intr_r = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (STATE !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", STATE); end
        n_cmp++; if (obs_str() !== 9'b000000001) begin n_bad++; $display("FAIL reset_strobes got %b want 000000001", obs_str()); end
        n_cmp++; if (INSTRET !== 32'd0) begin n_bad++; $display("FAIL reset_instret got %0d want 0", INSTRET); end
        @(negedge CLK);
        RST_N = 1'b1;
        drive(C_OP, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd0 || RST_OUT !== 1'b1) begin n_bad++; $display("FAIL init_cycle got st=%0d rst_out=%b want st=0 rst_out=1", STATE, RST_OUT); end
        tick();
        drive(C_OP, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd1 || MEM_RDEN1 !== 1'b1 || RST_OUT !== 1'b0) begin n_bad++; $display("FAIL fetch_cycle got st=%0d rden1=%b rst_out=%b want 1/1/0", STATE, MEM_RDEN1, RST_OUT); end
        n_cmp++; if (INSTRET !== 32'd0) begin n_bad++; $display("FAIL fetch_instret got %0d want 0", INSTRET); end
        tick();
        drive(C_OP, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd2) begin n_bad++; $display("FAIL exec_after_reset got %0d want 2", STATE); end
    endtask

    task automatic test_alu();
        logic [2:0] want;
        do_reset();
        drive(C_OP, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(C_OP, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
            want = (i % 2 == 0) ? 3'd1 : 3'd2;
            n_cmp++; if (STATE !== want) begin n_bad++; $display("FAIL alu_state[%0d] got %0d want %0d", i, STATE, want); end
            n_cmp++; if ({PC_WE, RF_WE} !== ((want == 3'd2) ? 2'b11 : 2'b00)) begin n_bad++; $display("FAIL alu_we[%0d] got %b st=%0d", i, {PC_WE, RF_WE}, want); end
            tick();
        end
        drive(C_OP, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (INSTRET !== 32'd3) begin n_bad++; $display("FAIL alu_instret got %0d want 3", INSTRET); end
    endtask

    task automatic test_load();
        do_reset();
        drive(C_LOAD, 3'd2, 1'b0, 1'b0); tick();
        drive(C_LOAD, 3'd2, 1'b0, 1'b0); tick();
        drive(C_LOAD, 3'd2, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd2 || MEM_RDEN2 !== 1'b1 || PC_WE !== 1'b0) begin n_bad++; $display("FAIL load_exec got st=%0d rden2=%b pc_we=%b want 2/1/0", STATE, MEM_RDEN2, PC_WE); end
        tick();
        drive(C_LOAD, 3'd2, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd3 || RF_WE !== 1'b1 || PC_WE !== 1'b1) begin n_bad++; $display("FAIL load_wb got st=%0d rf_we=%b pc_we=%b want 3/1/1", STATE, RF_WE, PC_WE); end
        n_cmp++; if (INSTRET !== 32'd0) begin n_bad++; $display("FAIL load_instret_wb got %0d want 0", INSTRET); end
        tick();
        drive(C_OP, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd1 || INSTRET !== 32'd1) begin n_bad++; $display("FAIL load_done got st=%0d instret=%0d want 1/1", STATE, INSTRET); end
    endtask

    task automatic test_intr_taken();
        int entries;
        do_reset();
        drive(C_OP, 3'd0, 1'b0, 1'b1); tick();
        drive(C_OP, 3'd0, 1'b1, 1'b1); tick();   // rising edge during FETCH
        drive(C_OP, 3'd0, 1'b1, 1'b1);
        n_cmp++; if (STATE !== 3'd2) begin n_bad++; $display("FAIL intr_exec got %0d want 2", STATE); end
        tick();
        drive(C_OP, 3'd0, 1'b1, 1'b1);
        n_cmp++; if (STATE !== 3'd4 || INT_TAKEN !== 1'b1 || PC_WE !== 1'b1) begin n_bad++; $display("FAIL intr_entry got st=%0d int=%b pc_we=%b want 4/1/1", STATE, INT_TAKEN, PC_WE); end
        n_cmp++; if (INSTRET !== 32'd1) begin n_bad++; $display("FAIL intr_instret got %0d want 1", INSTRET); end
        tick();
        drive(C_OP, 3'd0, 1'b1, 1'b1);
        n_cmp++; if (STATE !== 3'd1 || INSTRET !== 32'd1) begin n_bad++; $display("FAIL intr_exit got st=%0d instret=%0d want 1/1", STATE, INSTRET); end
        entries = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(C_OP, 3'd0, 1'b1, 1'b1);
            if (STATE == 3'd4) entries++;
        end
        n_cmp++; if (entries !== 0) begin n_bad++; $display("FAIL intr_held_high got %0d entries want 0", entries); end
        n_cmp++; if (INSTRET !== 32'd4) begin n_bad++; $display("FAIL intr_held_instret got %0d want 4", INSTRET); end
    endtask

    task automatic test_intr_masked();
        int entries;
        int first;
        do_reset();
        drive(C_OP, 3'd0, 1'b0, 1'b0); tick();
        entries = 0;
        first   = -1;
        for (int c = 0; c < 14; c++) begin
            drive(C_OP, 3'd0, (c == 0), (c >= 4));
            if (STATE == 3'd4) begin
                entries++;
                if (first < 0) first = c;
            end
            tick();
        end
        n_cmp++; if (entries !== 1) begin n_bad++; $display("FAIL masked_entries got %0d want 1", entries); end
        n_cmp++; if (first !== 6) begin n_bad++; $display("FAIL masked_entry_cycle got %0d want 6", first); end
    endtask

    task automatic test_async_reset();
        int entries;
        do_reset();
        drive(C_STORE, 3'd2, 1'b0, 1'b0); tick();
        drive(C_STORE, 3'd2, 1'b1, 1'b0); tick();
        drive(C_STORE, 3'd2, 1'b0, 1'b0);
        n_cmp++; if (STATE !== 3'd2 || MEM_WE2 !== 1'b1 || PC_WE !== 1'b1) begin n_bad++; $display("FAIL store_exec got st=%0d we2=%b pc_we=%b want 2/1/1", STATE, MEM_WE2, PC_WE); end
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (STATE !== 3'd0 || MEM_WE2 !== 1'b0 || PC_WE !== 1'b0 || RST_OUT !== 1'b1) begin n_bad++; $display("FAIL async_reset got st=%0d we2=%b pc_we=%b rst_out=%b want 0/0/0/1", STATE, MEM_WE2, PC_WE, RST_OUT); end
        @(negedge CLK);
        RST_N = 1'b1;
        entries = 0;
        for (int i = 0; i < 8; i++) begin
            drive(C_OP, 3'd0, 1'b0, 1'b1);
            if (STATE == 3'd4) entries++;
            tick();
        end
        n_cmp++; if (entries !== 0) begin n_bad++; $display("FAIL reset_clears_pending got %0d entries want 0", entries); end
    endtask

    task automatic test_random();
        logic [6:0] op;
        int         idx;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            idx = int'($urandom_range(0, 12));
            op  = (idx == 12) ? 7'($urandom) : op_tbl[idx];
            drive(op, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
            n_cmp++; if (obs_str() !== exp_str) begin n_bad++; $display("FAIL rand_strobes[%0d] got %b want %b op=%b st=%0d", i, obs_str(), exp_str, op, m_state); end
            n_cmp++; if (STATE !== m_state) begin n_bad++; $display("FAIL rand_state[%0d] got %0d want %0d", i, STATE, m_state); end
            n_cmp++; if (INSTRET !== m_instret) begin n_bad++; $display("FAIL rand_instret[%0d] got %0d want %0d", i, INSTRET, m_instret); end
            tick();
        end
    endtask

    initial begin
        RST_N  = 1'b0;
        op_r   = 7'd0;
        f3_r   = 3'd0;
        intr_r = 1'b0;
        mie_r  = 1'b0;
        model_reset();
        test_reset();
        test_alu();
        test_load();
        test_intr_taken();
        test_intr_masked();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d compared, want completion", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
